// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 event FIFO: register addresses,
// KBSTATUS bit layout and the buffered event entry format.
package ps2_pkg;

   localparam logic [7:0] ADDR_SCANCODE = 8'h04;
   localparam logic [7:0] ADDR_KBSTATUS = 8'h05;
   localparam logic [7:0] ADDR_FIFOCNT  = 8'h06;

   localparam int BIT_BSY = 7;
   localparam int BIT_OVF = 6;
   localparam int BIT_ERR = 3;
   localparam int BIT_RLS = 2;
   localparam int BIT_EXT = 1;
   localparam int BIT_PEN = 0;

   localparam int ENTRY_W = 10;

   typedef struct packed {
      logic       released;
      logic       extended;
      logic [7:0] code;
   } ps2_entry_t;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module ps2_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty && !flush;
   assign do_push  = push && (!full || do_pop) && !flush;
   assign overflow = push && full && !do_pop && !flush;
   assign head     = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_event_fifo.sv
// Buffers decoded PS/2 keyboard events and exposes them to the CPU through
// the SCANCODE (pop), KBSTATUS (status/flush) and FIFOCNT registers.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int         DEPTH    = 16,
   parameter logic [7:0] SCANCODE = ADDR_SCANCODE,
   parameter logic [7:0] KBSTATUS = ADDR_KBSTATUS,
   parameter logic [7:0] FIFOCNT  = ADDR_FIFOCNT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kb_interrupt,
   input  logic [7:0] scancode,
   input  logic       extended,
   input  logic       released,
   input  logic       ps2busy,
   input  logic       kberror,
   input  logic [7:0] zxuno_addr,
   input  logic       zxuno_regrd,
   input  logic       zxuno_regwr,
   input  logic [7:0] din,
   output logic [7:0] scancode_dout,
   output logic [7:0] kbstatus_dout,
   output logic [7:0] fifocnt_dout,
   output logic       oe_n_scancode,
   output logic       oe_n_kbstatus,
   output logic       oe_n_fifocnt
);

   localparam int AW = $clog2(DEPTH);

   logic             sc_sel, st_sel;
   logic             sc_rd_q, st_rd_q;
   logic             pop, ovf_clr, flush;
   logic             ovf;
   logic             full, empty, overflow;
   logic [AW:0]      count;
   ps2_entry_t       wr_entry;
   ps2_entry_t       head;
   logic [7:0]       status_next, status_idle;
   logic             din_unused;

   assign sc_sel        = (zxuno_addr == SCANCODE) && zxuno_regrd;
   assign st_sel        = (zxuno_addr == KBSTATUS) && zxuno_regrd;
   assign oe_n_scancode = ~sc_sel;
   assign oe_n_kbstatus = ~st_sel;
   assign oe_n_fifocnt  = ~((zxuno_addr == FIFOCNT) && zxuno_regrd);

   // A read access may hold regrd for many cycles; its side effect fires once,
   // on the first cycle after the enable drops.
   assign pop     = sc_rd_q && !sc_sel;
   assign ovf_clr = st_rd_q && !st_sel;
   assign flush   = zxuno_regwr && (zxuno_addr == KBSTATUS) && din[0];
   assign din_unused = ^din[7:1];

   assign wr_entry = '{released: released, extended: extended, code: scancode};

   ps2_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (kb_interrupt),
      .pop      (pop),
      .flush    (flush),
      .wdata    (wr_entry),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .count    (count)
   );

   always_comb begin
      status_idle          = '0;
      status_idle[BIT_BSY] = ps2busy;
      status_idle[BIT_ERR] = kberror;
      status_next          = status_idle;
      status_next[BIT_OVF] = ovf;
      status_next[BIT_RLS] = !empty && head.released;
      status_next[BIT_EXT] = !empty && head.extended;
      status_next[BIT_PEN] = !empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sc_rd_q       <= 1'b0;
         st_rd_q       <= 1'b0;
         ovf           <= 1'b0;
         scancode_dout <= 8'h00;
         kbstatus_dout <= status_idle;
         fifocnt_dout  <= 8'h00;
      end else begin
         sc_rd_q <= sc_sel;
         st_rd_q <= st_sel;
         if (overflow)     ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         scancode_dout <= empty ? 8'h00 : head.code;
         kbstatus_dout <= status_next;
         // A full 256-deep FIFO wraps to 8'h00 here; PEN still reports data.
         fifocnt_dout  <= 8'(count);
      end
   end

endmodule

// File: tb/tb_ps2_event_fifo.sv
// Self-checking bench for ps2_event_fifo: queue-based event model compared
// every cycle, plus directed scenarios with literal expected values.
module tb_ps2_event_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst, kb_interrupt, extended, released, ps2busy, kberror;
   logic       zxuno_regrd, zxuno_regwr;
   logic [7:0] scancode, zxuno_addr, din;
   logic [7:0] scancode_dout, kbstatus_dout, fifocnt_dout;
   logic       oe_n_scancode, oe_n_kbstatus, oe_n_fifocnt;

   int checks = 0;
   int passed = 0;

   logic [9:0] exp_q[$];
   logic       m_ovf = 1'b0, m_sc_prev = 1'b0, m_st_prev = 1'b0;
   logic [7:0] m_sc, m_st, m_cnt;
   bit         m_valid = 1'b0;

   always #5 clk = ~clk;

   ps2_event_fifo #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .kb_interrupt  (kb_interrupt),
      .scancode      (scancode),
      .extended      (extended),
      .released      (released),
      .ps2busy       (ps2busy),
      .kberror       (kberror),
      .zxuno_addr    (zxuno_addr),
      .zxuno_regrd   (zxuno_regrd),
      .zxuno_regwr   (zxuno_regwr),
      .din           (din),
      .scancode_dout (scancode_dout),
      .kbstatus_dout (kbstatus_dout),
      .fifocnt_dout  (fifocnt_dout),
      .oe_n_scancode (oe_n_scancode),
      .oe_n_kbstatus (oe_n_kbstatus),
      .oe_n_fifocnt  (oe_n_fifocnt)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
   endtask

   // Event-level model: a queue of entries, a sticky overflow flag and the
   // end-of-access detection for the two side-effecting reads.
   always @(posedge clk) begin : model
      bit sc_act, st_act, ovf_set;
      sc_act  = zxuno_regrd && (zxuno_addr == 8'h04);
      st_act  = zxuno_regrd && (zxuno_addr == 8'h05);
      ovf_set = 1'b0;
      if (rst) begin
         exp_q.delete();
         m_ovf = 1'b0; m_sc_prev = 1'b0; m_st_prev = 1'b0;
         m_sc = 8'h00; m_cnt = 8'h00;
         m_st = {ps2busy, 3'b000, kberror, 3'b000};
      end else begin
         if (exp_q.size() != 0) begin
            m_sc = exp_q[0][7:0];
            m_st = {ps2busy, m_ovf, 2'b00, kberror, exp_q[0][9], exp_q[0][8], 1'b1};
         end else begin
            m_sc = 8'h00;
            m_st = {ps2busy, m_ovf, 2'b00, kberror, 3'b000};
         end
         m_cnt = 8'(exp_q.size());
         if (zxuno_regwr && zxuno_addr == 8'h05 && din[0]) begin
            exp_q.delete();
         end else begin
            if (m_sc_prev && !sc_act && exp_q.size() != 0) void'(exp_q.pop_front());
            if (kb_interrupt) begin
               if (exp_q.size() < DEPTH) exp_q.push_back({released, extended, scancode});
               else ovf_set = 1'b1;
            end
         end
         if (ovf_set) m_ovf = 1'b1;
         else if (m_st_prev && !st_act) m_ovf = 1'b0;
         m_sc_prev = sc_act;
         m_st_prev = st_act;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("scancode_dout", scancode_dout, m_sc);
         chk("kbstatus_dout", kbstatus_dout, m_st);
         chk("fifocnt_dout",  fifocnt_dout,  m_cnt);
         chk("oe_n", {5'b0, oe_n_scancode, oe_n_kbstatus, oe_n_fifocnt},
             {5'b0, !(zxuno_regrd && zxuno_addr == 8'h04),
                    !(zxuno_regrd && zxuno_addr == 8'h05),
                    !(zxuno_regrd && zxuno_addr == 8'h06)});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      step();
      step();
      @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] c, input logic e, input logic r);
      scancode = c; extended = e; released = r; kb_interrupt = 1'b1;
      step();
      kb_interrupt = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input int n, output logic [7:0] d);
      zxuno_addr = a; zxuno_regrd = 1'b1;
      step();
      @(negedge clk);
      d = (a == 8'h04) ? scancode_dout : (a == 8'h05) ? kbstatus_dout : fifocnt_dout;
      repeat (n - 1) step();
      if (n == 1) step();
      zxuno_regrd = 1'b0;
      settle();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
      step();
      zxuno_regwr = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      rst = 1'b1; kb_interrupt = 1'b0; scancode = 8'h00; extended = 1'b0;
      released = 1'b0; ps2busy = 1'b0; kberror = 1'b0; zxuno_addr = 8'h00;
      zxuno_regrd = 1'b0; zxuno_regwr = 1'b0; din = 8'h00;
      repeat (3) step();
      rst = 1'b0;
      settle();
      chk("reset scancode", scancode_dout, 8'h00);
      chk("reset kbstatus", kbstatus_dout, 8'h00);
      chk("reset fifocnt",  fifocnt_dout,  8'h00);

      // Basic ordering and head flags
      strobe(8'h1C, 1'b0, 1'b0);
      strobe(8'h12, 1'b1, 1'b0);
      strobe(8'h1C, 1'b0, 1'b1);
      settle();
      chk("three cnt", fifocnt_dout, 8'h03);
      chk("three status", kbstatus_dout, 8'h01);
      rd(8'h04, 1, d); chk("read1", d, 8'h1C);
      chk("status ext head", kbstatus_dout, 8'h03);
      rd(8'h04, 1, d); chk("read2", d, 8'h12);
      chk("status rls head", kbstatus_dout, 8'h05);
      rd(8'h04, 1, d); chk("read3", d, 8'h1C);
      chk("drained cnt", fifocnt_dout, 8'h00);
      chk("drained status", kbstatus_dout, 8'h00);

      // Overflow: 17 pushes into a 16-deep FIFO
      for (int i = 0; i < 17; i++) strobe(8'h20 + 8'(i), 1'b0, 1'b0);
      settle();
      chk("full cnt", fifocnt_dout, 8'h10);
      chk("ovf status", kbstatus_dout, 8'h41);
      rd(8'h05, 1, d); chk("ovf read value", d, 8'h41);
      chk("ovf cleared", kbstatus_dout, 8'h01);
      for (int i = 0; i < 16; i++) rd(8'h04, 1, d);
      chk("last of 16", d, 8'h2F);
      chk("after drain cnt", fifocnt_dout, 8'h00);

      // Long read access pops exactly once
      for (int i = 0; i < 4; i++) strobe(8'h30 + 8'(i), 1'b0, 1'b0);
      rd(8'h04, 5, d);
      chk("long read value", d, 8'h30);
      chk("long read cnt", fifocnt_dout, 8'h03);
      wr(8'h05, 8'h01);
      settle();

      // Push on the pop cycle while full
      for (int i = 0; i < 16; i++) strobe(8'h40 + 8'(i), 1'b1, 1'b0);
      zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
      step(); step();
      zxuno_regrd = 1'b0; scancode = 8'h77; extended = 1'b0; released = 1'b0;
      kb_interrupt = 1'b1;
      step();
      kb_interrupt = 1'b0;
      settle();
      chk("pop+push cnt", fifocnt_dout, 8'h10);
      chk("pop+push status", kbstatus_dout, 8'h03);
      for (int i = 0; i < 16; i++) rd(8'h04, 1, d);
      chk("pop+push last", d, 8'h77);

      // Flush beats a simultaneous push; busy/error are pass-through
      ps2busy = 1'b1; kberror = 1'b1;
      for (int i = 0; i < 5; i++) strobe(8'h50 + 8'(i), 1'b0, 1'b0);
      zxuno_addr = 8'h05; din = 8'h01; zxuno_regwr = 1'b1;
      scancode = 8'h99; kb_interrupt = 1'b1;
      step();
      zxuno_regwr = 1'b0; kb_interrupt = 1'b0;
      settle();
      chk("flush cnt", fifocnt_dout, 8'h00);
      chk("flush status", kbstatus_dout, 8'h88);
      strobe(8'h5A, 1'b0, 1'b0);
      wr(8'h05, 8'h00);
      settle();
      chk("din0 write ignored", fifocnt_dout, 8'h01);
      ps2busy = 1'b0; kberror = 1'b0;
      wr(8'h05, 8'h01);
      settle();

      // Reset in the middle of a SCANCODE read
      strobe(8'h61, 1'b0, 1'b0);
      strobe(8'h62, 1'b0, 1'b0);
      zxuno_addr = 8'h04; zxuno_regrd = 1'b1;
      step(); step();
      rst = 1'b1;
      step(); step();
      rst = 1'b0; zxuno_regrd = 1'b0;
      settle();
      chk("post-reset cnt", fifocnt_dout, 8'h00);
      strobe(8'h55, 1'b0, 1'b0);
      strobe(8'h66, 1'b0, 1'b0);
      settle();
      chk("post-reset push cnt", fifocnt_dout, 8'h02);
      chk("post-reset head", scancode_dout, 8'h55);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
